// File: rtl/updown_sat_counter.sv
// Up/down occupancy counter saturating at 0 and MAX_CNT; sticky ovf/udf flags; optional UPDN_CNT_PEAK_EN high-watermark.
// Latency: one edge from push/pop/load to cnt; flags are decodes of registered cnt.
// Backpressure: none; refused push/pop hold cnt and raise the sticky error instead.
module updown_sat_counter #(
    parameter int MAX_CNT   = 5,
    parameter int WIDTH     = 3,
    parameter int AFULL_TH  = 4,
    parameter int AEMPTY_TH = 1,
    parameter int RST_VAL   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear_err,
    output logic [WIDTH-1:0] cnt,
    output logic             full,
    output logic             empty,
    output logic             afull,
    output logic             aempty,
`ifdef UPDN_CNT_PEAK_EN
    output logic [WIDTH-1:0] peak,
`endif
    output logic             ovf_err,
    output logic             udf_err
);

    generate
        if (MAX_CNT < 1 || WIDTH < 1 || (2 ** WIDTH) <= MAX_CNT ||
            AFULL_TH < 0 || AFULL_TH > MAX_CNT ||
            AEMPTY_TH < 0 || AEMPTY_TH > MAX_CNT ||
            RST_VAL < 0 || RST_VAL > MAX_CNT) begin : g_param_chk
            $fatal(1, "updown_sat_counter: illegal parameter combination");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_CNT);
    localparam logic [WIDTH-1:0] AFULL_W  = WIDTH'(AFULL_TH);
    localparam logic [WIDTH-1:0] AEMPTY_W = WIDTH'(AEMPTY_TH);
    localparam logic [WIDTH-1:0] RST_W    = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] r_cnt;
    logic             r_ovf_err;
    logic             r_udf_err;

    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_ovf_evt;
    logic             w_udf_evt;
    logic             w_push_only;
    logic             w_pop_only;

    // Push and pop together cancel out, so only a lone request moves the count.
    assign w_push_only = push & ~pop;
    assign w_pop_only  = pop & ~push;

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_ovf_evt = 1'b0;
        w_udf_evt = 1'b0;
        if (load) begin
            if (load_val > MAX_W) begin
                w_cnt_nxt = MAX_W;
                w_ovf_evt = 1'b1;
            end else begin
                w_cnt_nxt = load_val;
            end
        end else if (w_push_only) begin
            if (r_cnt == MAX_W) begin
                w_ovf_evt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + WIDTH'(1);
            end
        end else if (w_pop_only) begin
            if (r_cnt == '0) begin
                w_udf_evt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= RST_W;
            r_ovf_err <= 1'b0;
            r_udf_err <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            // A new error event wins over a same-cycle clear.
            r_ovf_err <= w_ovf_evt | (r_ovf_err & ~clear_err);
            r_udf_err <= w_udf_evt | (r_udf_err & ~clear_err);
        end
    end

`ifdef UPDN_CNT_PEAK_EN
    logic [WIDTH-1:0] r_peak;
    logic [WIDTH-1:0] w_peak_nxt;

    always_comb begin
        w_peak_nxt = r_peak;
        if (clear_err || w_cnt_nxt > r_peak) begin
            w_peak_nxt = w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_peak <= RST_W;
        end else begin
            r_peak <= w_peak_nxt;
        end
    end

    assign peak = r_peak;
`endif

    assign cnt     = r_cnt;
    assign full    = (r_cnt == MAX_W);
    assign empty   = (r_cnt == '0);
    assign afull   = (r_cnt >= AFULL_W);
    assign aempty  = (r_cnt <= AEMPTY_W);
    assign ovf_err = r_ovf_err;
    assign udf_err = r_udf_err;

endmodule

// File: doc/updown_sat_counter.md
Name: updown_sat_counter

Overview:
Parametrised, fully clocked up/down occupancy counter with saturation at 0 and MAX_CNT. Generalises the fixed 0..5 push/pop counter used for slot and credit tracking. Adds:
- simultaneous push/pop handling
- full/empty and threshold flags
- synchronous load
- sticky overflow/underflow error flags
Sits beside small buffers and arbiters as their occupancy and credit tracker.

Parameters:
MAX_CNT, 5, saturation ceiling; legal range >= 1.
WIDTH, 3, counter width; must satisfy 2**WIDTH > MAX_CNT.
AFULL_TH, 4, almost-full threshold; legal range 0..MAX_CNT.
AEMPTY_TH, 1, almost-empty threshold; legal range 0..MAX_CNT.
RST_VAL, 0, count value after reset; legal range 0..MAX_CNT.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous reset, active-high.
push  input  1  increment request.
pop  input  1  decrement request.
load  input  1  synchronous load strobe.
load_val  input  WIDTH  value to load.
clear_err  input  1  clears sticky error flags.
cnt  output  WIDTH  registered count.
full  output  1  cnt == MAX_CNT.
empty  output  1  cnt == 0.
afull  output  1  cnt >= AFULL_TH.
aempty  output  1  cnt <= AEMPTY_TH.
ovf_err  output  1  sticky: push refused at full, or load clamped.
udf_err  output  1  sticky: pop refused at empty.

Behaviour:
- Clocking and reset: one clock domain (clk). Reset is synchronous and active-high on port reset, sampled on the rising edge of clk. No latches; all state is in flops.
- Reset values: cnt=RST_VAL, ovf_err=0, udf_err=0. Flags follow from cnt=RST_VAL (defaults: empty=1, aempty=1, full=0, afull=0).
- Update priority per edge: reset > load > push/pop.
- load=1: cnt <= min(load_val, MAX_CNT). If load_val > MAX_CNT, set ovf_err. push/pop are ignored that cycle, and no udf/ovf error arises from them.
- push=1, pop=0:
  - cnt<MAX_CNT: cnt+1.
  - cnt==MAX_CNT: hold and set ovf_err.
- pop=1, push=0:
  - cnt>0: cnt-1.
  - cnt==0: hold and set udf_err.
- push=1, pop=1: cnt unchanged at any value, including 0 and MAX_CNT. No error is raised.
- push=0, pop=0: hold.
- Latency: one edge from request to new cnt.
- full/empty/afull/aempty are combinational decodes of the registered cnt. They are valid in the same cycle as cnt; no extra delay.
- Arithmetic: unsigned, WIDTH bits. Never wraps; saturation is explicit.
- clear_err=1: both sticky flags clear on the next edge. If a new error event occurs in the same cycle, the flag is set (set wins over clear).
- reset asserted mid-sequence: all state returns to reset values on that edge regardless of other inputs.
- Parameter violations (e.g. 2**WIDTH <= MAX_CNT, thresholds > MAX_CNT) are caught by an elaboration-time check that stops simulation.

Optional Feature:
Macro: UPDN_CNT_PEAK_EN
- Defined:
  - Adds output port peak [WIDTH], a high-watermark register.
  - Reset value is RST_VAL.
  - Each edge: peak <= max(peak, next_cnt), so peak >= cnt always holds.
  - clear_err additionally reloads peak with next_cnt.
- Undefined: the peak port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset then push x7 (defaults) -> cnt 1,2,3,4,5,5,5; full=1 from cnt=5; ovf_err=1 after the 6th push edge; udf_err=0.
2. From cnt=0, pop x2 -> cnt stays 0; udf_err=1 after the 1st pop edge. Then clear_err one cycle -> udf_err=0.
3. Simultaneous push+pop held at cnt=0, 3 and 5 (3 cycles each) -> cnt unchanged at each value; no error flags.
4. load=1, load_val=7 together with push=1 -> cnt=5, ovf_err=1. Next: load_val=2 -> cnt=2, aempty=0, afull=0.
5. cnt=3, assert reset together with push and load -> next cnt=0, both errors 0, empty=1.
6. With UPDN_CNT_PEAK_EN: push to 4, pop to 1 -> peak=4. Then clear_err -> peak=1.
